load_addr_queue: RTL and testbench
==================================

# load_addr_queue

Parametrised load address stage between the execute-stage load AGU issue and the load data stage. It adds base and offset to form the effective address and builds a byte-enable mask for byte, half, word or double accesses. Results are held in a DEPTH-entry in-order FIFO. Entries track branch masks every cycle: they clear resolved bits on a correct prediction and are squashed on a mispredict. Its handshake decouples execute issue from load-data/load-buffer back-pressure, replacing the single-register load address stage.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥2
- ADDR_W, 32: address width
- BYTES, 4: data bus bytes, 4 or 8
- BM_W, 4: branch mask width
- TAG_W, 6: physical destination register index width
- SQ_W, 3: store-queue tail pointer width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  load packet offered
- in_ready  out  1  queue can accept this cycle
- in_base  in  ADDR_W  source operand 1
- in_offset  in  ADDR_W  source operand 2 / immediate
- in_func  in  3  [1:0] size (0 B, 1 H, 2 W, 3 D); [2] unsigned
- in_dest  in  TAG_W  destination tag
- in_bm  in  BM_W  branch mask
- in_sq_tail  in  SQ_W  store-queue tail snapshot
- out_valid  out  1  head entry valid and not squashed this cycle
- out_ready  in  1  load data stage AND load buffer free
- out_addr  out  ADDR_W  effective address
- out_mask  out  BYTES  byte enables
- out_misalign  out  1  access crosses bus boundary or illegal size
- out_func, out_dest, out_sq_tail  out  3/TAG_W/SQ_W  pass-through
- out_bm  out  BM_W  head mask with this cycle's resolve cleared
- b_resolve  in  BM_W  one-hot resolving branch, 0 if none
- b_mispred  in  1  the resolving branch mispredicted

## Operation
- The block is a circular FIFO. State is head, tail, and count (0..DEPTH); each entry holds a valid bit plus the fields above.
- in_ready = (count != DEPTH). A full queue does not accept even when it dequeues the same cycle.
- Enqueue on in_valid & in_ready:
  - addr = (in_base + in_offset) mod 2^ADDR_W, computed at enqueue and stored.
  - Base mask by size: B 1, H 2'b11, W 4'hF, D 8'hFF. Size D with BYTES=4 gives mask 0 and misalign=1.
  - The base mask is shifted left by addr[log2(BYTES)-1:0]. Set-bits shifted past bit BYTES-1 are dropped and set misalign.
  - The stored bm has the current cycle's resolve applied. An incoming packet hit by a mispredict is written as an invalid entry: it still consumes a slot and count increments.
- Every cycle, for each valid entry with bm & b_resolve != 0:
  - b_mispred=1: the entry's valid bit clears.
  - b_mispred=0: bm &= ~b_resolve.
  - Entries not tagged with the resolving branch are unaffected.
- Output is driven combinationally from the head entry:
  - out_valid = count>0 & head.valid & ~(b_mispred & |(head.bm & b_resolve)).
  - out_bm = head.bm & ~b_resolve.
- Pop conditions (head++, count--):
  - out_valid & out_ready, or
  - count>0 & head entry invalid (a bubble), or
  - the head is squashed this cycle.
- Only one pop per cycle; invalid holes in the middle drain one per cycle once they reach the head.
- Simultaneous enqueue and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.
- When count = 0, out_* data fields are don't-care and out_valid = 0.

## Timing
- Reset:
  - head = tail = count = 0 and all valid bits = 0.
  - in_ready=1, out_valid=0, out_misalign=0, out_bm=0.
  - Reset overrides any same-cycle enqueue, pop or resolve.
- Latency: a packet accepted in cycle t can appear on out_* in cycle t+1 at the earliest. There is no bypass from input to output.
- Throughput: one enqueue and one dequeue per cycle.
- Outputs are stable while out_valid & ~out_ready, except for:
  - out_bm losing resolved bits, and
  - out_valid dropping on a squash.
- Branch resolve takes effect in the same cycle on the outputs, and in stored state from t+1.

## Test plan
- Reset, then enqueue base=0x1000, offset=0x6, func=1 (H), out_ready=1 -> next cycle out_valid=1, out_addr=0x1006, out_mask=4'b1100, out_misalign=0.
- BYTES=4, func=2 (W) at addr 0x1002 -> out_mask=4'b1100 and out_misalign=1. With BYTES=8, func=3 at 0x2000 -> out_mask=8'hFF and misalign=0.
- Hold out_ready=0 and enqueue 4 packets -> in_ready=0 after the 4th and a 5th is refused. Raise out_ready -> packets drain in order, one per cycle, with tail wrap checked.
- Queue holds entries with bm 0001, 0010, 0001. Apply b_resolve=0001, b_mispred=1 -> both 0001 entries are squashed and never appear on the output. The 0010 entry is delivered, and count reaches 0 after 3 pops.
- Head entry has bm=0011 with out_ready=0. Apply b_resolve=0010, b_mispred=0 -> out_bm=0001 in the same cycle and the stored bm is 0001 afterward.
- Enqueue a packet with in_bm=0100 in the same cycle as b_resolve=0100, b_mispred=1 -> the slot is consumed but never output. Asserting reset mid-operation empties the queue on the next cycle.

Source files
------------

// File: rtl/load_addr_queue.sv
// Load address queue: forms effective address and byte mask, then buffers
// load packets in order while tracking branch masks for resolve/squash.
module load_addr_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int BYTES  = 4,
    parameter int BM_W   = 4,
    parameter int TAG_W  = 6,
    parameter int SQ_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] in_offset,
    input  logic [2:0]        in_func,
    input  logic [TAG_W-1:0]  in_dest,
    input  logic [BM_W-1:0]   in_bm,
    input  logic [SQ_W-1:0]   in_sq_tail,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [BYTES-1:0]  out_mask,
    output logic              out_misalign,
    output logic [2:0]        out_func,
    output logic [TAG_W-1:0]  out_dest,
    output logic [SQ_W-1:0]   out_sq_tail,
    output logic [BM_W-1:0]   out_bm,
    input  logic [BM_W-1:0]   b_resolve,
    input  logic              b_mispred
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(BYTES);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_mis;
    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [BYTES-1:0]  e_mask [DEPTH];
    logic [2:0]        e_func [DEPTH];
    logic [TAG_W-1:0]  e_dest [DEPTH];
    logic [BM_W-1:0]   e_bm   [DEPTH];
    logic [SQ_W-1:0]   e_sq   [DEPTH];

    logic [ADDR_W-1:0] sum;
    logic [7:0]        base_mask;
    logic [15:0]       wide;
    logic              too_big;
    logic [BYTES-1:0]  new_mask;
    logic              new_mis;
    logic              nonempty;
    logic              head_hit;
    logic              in_hit;
    logic              push;
    logic              pop;

    assign sum = in_base + in_offset;

    always_comb begin
        base_mask = 8'h00;
        unique case (in_func[1:0])
            2'd0: base_mask = 8'h01;
            2'd1: base_mask = 8'h03;
            2'd2: base_mask = 8'h0F;
            2'd3: base_mask = 8'hFF;
        endcase
    end

    // Bits pushed above the bus width flag a boundary-crossing access
    assign wide     = {8'h00, base_mask} << sum[OW-1:0];
    assign too_big  = (in_func[1:0] == 2'd3) && (BYTES == 4);
    assign new_mask = too_big ? '0 : wide[BYTES-1:0];
    assign new_mis  = too_big | (|(wide >> BYTES));

    assign nonempty = (count != '0);
    assign head_hit = b_mispred & (|(e_bm[head] & b_resolve));
    assign in_hit   = b_mispred & (|(in_bm & b_resolve));

    assign in_ready  = (count != FULL);
    assign out_valid = nonempty & e_valid[head] & ~head_hit;

    assign push = in_valid & in_ready;
    assign pop  = nonempty &
                  ((out_valid & out_ready) | ~e_valid[head] | head_hit);

    assign out_addr     = e_addr[head];
    assign out_mask     = e_mask[head];
    assign out_misalign = nonempty & e_mis[head];
    assign out_func     = e_func[head];
    assign out_dest     = e_dest[head];
    assign out_sq_tail  = e_sq[head];
    assign out_bm       = nonempty ? (e_bm[head] & ~b_resolve) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && b_mispred && |(e_bm[i] & b_resolve))
                    e_valid[i] <= 1'b0;
            end
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                e_valid[tail] <= ~in_hit;
                tail          <= tail + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; validity is tracked separately above
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && !b_mispred && |(e_bm[i] & b_resolve))
                e_bm[i] <= e_bm[i] & ~b_resolve;
        end
        if (push) begin
            e_addr[tail] <= sum;
            e_mask[tail] <= new_mask;
            e_mis[tail]  <= new_mis;
            e_func[tail] <= in_func;
            e_dest[tail] <= in_dest;
            e_bm[tail]   <= in_bm & ~b_resolve;
            e_sq[tail]   <= in_sq_tail;
        end
    end

endmodule

// File: tb/tb_load_addr_queue.sv
// Randomized scoreboard bench for load_addr_queue with a queue-based
// reference model and a few directed scenarios.
module tb_load_addr_queue;

    localparam int DEPTH = 4;
    localparam int BYTES = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_offset;
    logic [2:0]  in_func;
    logic [5:0]  in_dest;
    logic [3:0]  in_bm;
    logic [2:0]  in_sq_tail;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [3:0]  out_mask;
    logic        out_misalign;
    logic [2:0]  out_func;
    logic [5:0]  out_dest;
    logic [2:0]  out_sq_tail;
    logic [3:0]  out_bm;
    logic [3:0]  b_resolve;
    logic        b_mispred;

    logic        v8;
    logic [31:0] base8;
    logic        r8, ov8, omis8;
    logic [31:0] oa8;
    logic [7:0]  om8;
    logic [2:0]  of8, osq8;
    logic [5:0]  od8;
    logic [3:0]  obm8;

    always #5 clock = ~clock;

    load_addr_queue u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_offset(in_offset),
        .in_func(in_func), .in_dest(in_dest),
        .in_bm(in_bm), .in_sq_tail(in_sq_tail),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_mask(out_mask),
        .out_misalign(out_misalign), .out_func(out_func),
        .out_dest(out_dest), .out_sq_tail(out_sq_tail),
        .out_bm(out_bm), .b_resolve(b_resolve),
        .b_mispred(b_mispred)
    );

    load_addr_queue #(.BYTES(8)) u_d8 (
        .clock(clock), .reset(reset),
        .in_valid(v8), .in_ready(r8),
        .in_base(base8), .in_offset(32'h0),
        .in_func(3'd3), .in_dest(6'd0),
        .in_bm(4'd0), .in_sq_tail(3'd0),
        .out_valid(ov8), .out_ready(1'b1),
        .out_addr(oa8), .out_mask(om8),
        .out_misalign(omis8), .out_func(of8),
        .out_dest(od8), .out_sq_tail(osq8),
        .out_bm(obm8), .b_resolve(4'd0),
        .b_mispred(1'b0)
    );

    typedef struct {
        bit          live;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic        mis;
        logic [2:0]  func;
        logic [5:0]  dest;
        logic [3:0]  bm;
        logic [2:0]  sq;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Byte enables from access size and address, straight from the rules
    task automatic calc(input logic [31:0] a, input logic [1:0] sz,
                        output logic [7:0] m, output logic mis);
        int n;
        int off;
        int full;
        n = 1 << sz;
        off = int'(a % 32'(BYTES));
        if (n > BYTES) begin
            m = 8'h00;
            mis = 1'b1;
        end else begin
            full = ((1 << n) - 1) << off;
            m = 8'(full & ((1 << BYTES) - 1));
            mis = (off + n > BYTES);
        end
    endtask

    task automatic step();
        ent_t h;
        ent_t e;
        bit   hv, hit, ov, pop, acc;
        if (reset) begin
            mq.delete();
            return;
        end
        hv = mq.size() > 0;
        hit = 0;
        ov = 0;
        if (hv) begin
            h = mq[0];
            hit = h.live && b_mispred && ((h.bm & b_resolve) != 0);
            ov = h.live && !hit;
        end
        pop = hv && ((ov && out_ready) || !h.live || hit);
        acc = in_valid && (mq.size() < DEPTH);
        if (pop) void'(mq.pop_front());
        foreach (mq[i]) begin
            if (mq[i].live && ((mq[i].bm & b_resolve) != 0)) begin
                if (b_mispred) mq[i].live = 0;
                else mq[i].bm = mq[i].bm & ~b_resolve;
            end
        end
        if (acc) begin
            e.addr = in_base + in_offset;
            calc(e.addr, in_func[1:0], e.mask, e.mis);
            e.func = in_func;
            e.dest = in_dest;
            e.sq = in_sq_tail;
            e.bm = in_bm & ~b_resolve;
            e.live = !(b_mispred && ((in_bm & b_resolve) != 0));
            mq.push_back(e);
        end
    endtask

    task automatic check_out();
        ent_t h;
        bit   ev;
        ev = 0;
        if (mq.size() > 0) begin
            h = mq[0];
            ev = h.live && !(b_mispred && ((h.bm & b_resolve) != 0));
        end
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("addr", out_addr, h.addr);
            chk("mask", out_mask, h.mask);
            chk("misalign", out_misalign, h.mis);
            chk("passthru", {out_func, out_dest, out_sq_tail},
                {h.func, h.dest, h.sq});
            chk("bm", out_bm, h.bm & ~b_resolve);
        end else if (mq.size() == 0) begin
            chk("idle", {out_bm, out_misalign}, 5'd0);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            #2;
            check_out();
        end
    end

    task automatic tick();
        @(posedge clock);
        step();
        @(negedge clock);
    endtask

    task automatic drive(bit v, logic [31:0] b, logic [31:0] o,
                         logic [2:0] f, logic [3:0] bm, bit rdy,
                         logic [3:0] res, bit mp);
        in_valid   = v;
        in_base    = b;
        in_offset  = o;
        in_func    = f;
        in_bm      = bm;
        out_ready  = rdy;
        b_resolve  = res;
        b_mispred  = mp;
        in_dest    = 6'($urandom);
        in_sq_tail = 3'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        v8 = 1'b0;
        base8 = 32'h0;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        mon_en = 1;
        tick();
        reset = 1'b0;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);

        drive(1, 32'h1000, 32'h6, 3'd1, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("h_addr", out_addr, 32'h1006);
        chk("h_mask", {out_valid, out_mask, out_misalign}, 6'b1_1100_0);
        tick();

        drive(1, 32'h1000, 32'h2, 3'd2, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("w_mis", {out_valid, out_mask, out_misalign}, 6'b1_1100_1);
        tick();

        v8 = 1'b1;
        base8 = 32'h2000;
        tick();
        base8 = 32'h2004;
        #3;
        chk("d8_ok", {ov8, oa8, om8, omis8}, {1'b1, 32'h2000, 8'hFF, 1'b0});
        chk("d8_pass", {r8, of8, od8, osq8, obm8}, {1'b1, 3'd3, 13'd0});
        tick();
        v8 = 1'b0;
        #3;
        chk("d8_mis", {ov8, om8, omis8}, {1'b1, 8'hF0, 1'b1});
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h100 * i, 32'h4, 3'd2, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("full", in_ready, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (6) tick();

        drive(1, 32'h40, 0, 3'd2, 4'b0001, 0, 0, 0);
        tick();
        drive(1, 32'h44, 0, 3'd2, 4'b0010, 0, 0, 0);
        tick();
        drive(1, 32'h48, 0, 3'd2, 4'b0001, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 4'b0001, 1);
        #3;
        chk("sq_head", out_valid, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("sq_keep", {out_valid, out_addr}, {1'b1, 32'h44});
        repeat (4) tick();
        chk("sq_empty", {out_valid, in_ready}, 2'b01);

        drive(1, 32'h80, 0, 3'd0, 4'b0011, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 4'b0010, 0);
        #3;
        chk("res_same", out_bm, 4'b0001);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("res_held", out_bm, 4'b0001);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) tick();

        drive(1, 32'hC0, 0, 3'd0, 4'b0100, 1, 4'b0100, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("in_squash", out_valid, 1'b0);
        repeat (2) tick();

        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + i, 0, 3'd0, 0, 0, 0, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        chk("mid_rst", {out_valid, in_ready}, 2'b01);
        tick();

        for (int c = 0; c < 3000; c++) begin
            drive($urandom % 4 != 0, $urandom, $urandom, 3'($urandom),
                  4'($urandom), $urandom % 3 != 0,
                  ($urandom % 3 == 0) ? 4'(1 << ($urandom % 4)) : 4'd0,
                  1'($urandom));
            reset = ($urandom % 300 == 0);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (8) tick();
        chk("final_empty", {out_valid, in_ready}, 2'b01);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
